// File: rtl/mips_mem_pkg.sv
// Shared MIPS load/store opcode constants, FSM state type and decode helpers
// for the memory access unit.
package mips_mem_pkg;

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLwl = 6'h22;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpLwr = 6'h26;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OpLb, OpLh, OpLwl, OpLw, OpLbu, OpLhu, OpLwr};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  // Halfwords may not straddle the word; full words must be aligned.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] offset);
    return ((op inside {OpLh, OpLhu, OpSh}) && (offset == 2'd3)) ||
           ((op inside {OpLw, OpSw}) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction and LWL/LWR merge of the bus word with old rt.
module load_align
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] rt,
  output logic [DATA_W-1:0] result
);

  logic [4:0]        sh_r;
  logic [4:0]        sh_l;
  logic [DATA_W-1:0] shifted;

  // 8*offset and 8*(3-offset)
  assign sh_r = {offset, 3'b000};
  assign sh_l = {~offset, 3'b000};

  always_comb begin
    shifted = readdata >> sh_r;
    result  = readdata;
    case (opcode)
      OpLb:    result = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      OpLbu:   result = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      OpLh:    result = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      OpLhu:   result = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      OpLwl:   result = (readdata << sh_l) | (rt & ~({DATA_W{1'b1}} << sh_l));
      OpLwr:   result = shifted | (rt & ~({DATA_W{1'b1}} >> sh_r));
      default: result = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding MIPS load/store unit bridging the CPU to a
// waitrequest-style memory bus.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_offset,
  input  logic [3:0]        req_byteenable,
  input  logic [DATA_W-1:0] req_rt,
  output logic [31:0]       address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [3:0]        byteenable,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  output logic              result_valid,
  output logic [DATA_W-1:0] load_result,
  output logic              misaligned
);

  state_e            state;
  logic [5:0]        op_q;
  logic [1:0]        offset_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] aligned;

  assign req_ready = (state == StIdle) && !reset;

  always_comb begin
    store_data = req_rt << {req_offset, 3'b000};
    if (req_opcode == OpSw) store_data = req_rt;
  end

  load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .opcode  (op_q),
    .offset  (offset_q),
    .readdata(readdata),
    .rt      (rt_q),
    .result  (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      op_q         <= '0;
      offset_q     <= '0;
      rt_q         <= '0;
      address      <= '0;
      writedata    <= '0;
      byteenable   <= '0;
      read         <= 1'b0;
      write        <= 1'b0;
      result_valid <= 1'b0;
      misaligned   <= 1'b0;
      load_result  <= '0;
    end else begin
      result_valid <= 1'b0;
      misaligned   <= 1'b0;
      case (state)
        StIdle: begin
          if (req_valid) begin
            op_q       <= req_opcode;
            offset_q   <= req_offset;
            rt_q       <= req_rt;
            address    <= req_addr;
            byteenable <= req_byteenable;
            writedata  <= store_data;
            if (is_misaligned(req_opcode, req_offset)) begin
              state        <= StDone;
              result_valid <= 1'b1;
              misaligned   <= 1'b1;
            end else if (is_load(req_opcode)) begin
              state <= StRead;
              read  <= 1'b1;
            end else if (is_store(req_opcode)) begin
              state <= StWrite;
              write <= 1'b1;
            end else begin
              // Unknown opcode completes as a no-op without touching the bus.
              state        <= StDone;
              result_valid <= 1'b1;
            end
          end
        end
        StRead: begin
          if (!waitrequest) begin
            read         <= 1'b0;
            load_result  <= aligned;
            state        <= StDone;
            result_valid <= 1'b1;
          end
        end
        StWrite: begin
          if (!waitrequest) begin
            write        <= 1'b0;
            state        <= StDone;
            result_valid <= 1'b1;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule
